// File: rtl/mul_div_ctrl.sv
// ---------------------------------------------------------------------------
// mul_div_ctrl
//
// Sequencer between the execute stage and an iterative multiply/divide
// datapath for the RISC-V M extension. It latches an instruction's operands,
// holds the pipeline while the datapath works, then writes back the
// requested word for one cycle. A one-entry result cache lets a follow-up
// instruction on the same operands (e.g. REM after DIV, or MUL after MULH)
// finish without touching the datapath. A watchdog aborts a BUSY phase that
// never sees md_ready_i.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i            execute stage holds an M-extension instruction
//   req_op_i               funct3 of that instruction
//   req_rs1_i, req_rs2_i   source operands
//   req_rd_i               destination register index
//   flush_i                pipeline flush, overrides everything else
//   md_req_o               request to the datapath, high only while BUSY
//   md_op_o                latched funct3 for the datapath
//   md_opcode_o            constant R-type opcode 7'b0110011
//   md_rs1_o, md_rs2_o     latched operands, stable during a request
//   md_ready_i             datapath finished
//   md_high_i, md_low_i    datapath high word/remainder, low word/quotient
//   stall_o                hold the pipeline
//   wb_valid_o             one-cycle write-back strobe
//   wb_rd_o, wb_data_o     write-back destination and data
//   err_o                  watchdog timeout pulse, coincident with wb_valid_o
// ---------------------------------------------------------------------------
module mul_div_ctrl #(
   parameter int MAX_CYCLES = 40
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic [2:0]  req_op_i,
   input  logic [31:0] req_rs1_i,
   input  logic [31:0] req_rs2_i,
   input  logic [4:0]  req_rd_i,
   input  logic        flush_i,
   output logic        md_req_o,
   output logic [2:0]  md_op_o,
   output logic [6:0]  md_opcode_o,
   output logic [31:0] md_rs1_o,
   output logic [31:0] md_rs2_o,
   input  logic        md_ready_i,
   input  logic [31:0] md_high_i,
   input  logic [31:0] md_low_i,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        err_o
);

   localparam int CNT_W = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [2:0]       op_q;
   logic [31:0]      rs1_q;
   logic [31:0]      rs2_q;
   logic [4:0]       rd_q;
   logic [31:0]      result_q;
   logic             timeout_q;
   logic [CNT_W-1:0] cnt_q;

   logic             cache_valid_q;
   logic [2:0]       cache_op_q;
   logic [31:0]      cache_rs1_q;
   logic [31:0]      cache_rs2_q;
   logic [31:0]      cache_high_q;
   logic [31:0]      cache_low_q;

   logic op_compat;
   logic cache_hit;
   logic accept;
   logic hit_accept;
   logic capture;
   logic timeout;
   logic abort;

   // MUL, DIV and DIVU return the low word (product low / quotient); the
   // high-product multiplies and both remainders return the high word.
   function automatic logic [31:0] select_word(input logic [2:0]  op,
                                               input logic [31:0] high,
                                               input logic [31:0] low);
      return (op == 3'b000 || op[2:1] == 2'b10) ? low : high;
   endfunction

   // A cached entry can serve the new request when the operands match and
   // the cached datapath run produced the word the new op wants: the same
   // op, the sibling of a divide (DIV/REM or DIVU/REMU share one run), or a
   // plain MUL after any multiply, since the low product word is the same
   // for every signedness.
   always_comb begin
      op_compat = (req_op_i == cache_op_q)
                  || (req_op_i[2] && cache_op_q[2] && (req_op_i[0] == cache_op_q[0]))
                  || ((req_op_i == 3'b000) && !cache_op_q[2]);
      cache_hit = cache_valid_q && (req_rs1_i == cache_rs1_q)
                  && (req_rs2_i == cache_rs2_q) && op_compat;
   end

   // Next-state logic plus the one-cycle action strobes used by the
   // register block. In BUSY a flush beats a same-cycle md_ready_i, and a
   // real result beats the watchdog when both land in the last cycle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      hit_accept = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      abort      = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid_i && !flush_i) begin
               accept = 1'b1;
               if (cache_hit) begin
                  hit_accept = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (flush_i) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (md_ready_i) begin
               capture    = 1'b1;
               state_next = DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state. stall_o is also held low while
   // reset is asserted so the pipeline sees a quiet controller during reset.
   // A flush in DONE swallows the write-back and any error pulse.
   always_comb begin
      md_req_o    = (state == BUSY);
      stall_o     = rst_ni && (((state == IDLE) && req_valid_i && !flush_i)
                               || (state == BUSY));
      wb_valid_o  = (state == DONE) && !flush_i;
      err_o       = (state == DONE) && !flush_i && timeout_q;
      md_op_o     = op_q;
      md_rs1_o    = rs1_q;
      md_rs2_o    = rs2_q;
      md_opcode_o = 7'b0110011;
      wb_rd_o     = rd_q;
      wb_data_o   = result_q;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latch and result register. On a hit the result comes straight
   // from the cache; on completion it comes from the datapath; on a timeout
   // it is forced to zero and the error flag is armed for the DONE cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q      <= 3'd0;
         rs1_q     <= 32'd0;
         rs2_q     <= 32'd0;
         rd_q      <= 5'd0;
         result_q  <= 32'd0;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= req_op_i;
            rs1_q     <= req_rs1_i;
            rs2_q     <= req_rs2_i;
            rd_q      <= req_rd_i;
            timeout_q <= 1'b0;
         end
         if (hit_accept) begin
            result_q <= select_word(req_op_i, cache_high_q, cache_low_q);
         end
         if (capture) begin
            result_q <= select_word(op_q, md_high_i, md_low_i);
         end
         if (timeout) begin
            result_q  <= 32'd0;
            timeout_q <= 1'b1;
         end
      end
   end

   // Watchdog counter: counts consecutive BUSY cycles and restarts from
   // zero whenever the controller is anywhere else.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (state == BUSY) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   // Result cache. Only a genuine datapath completion fills it, with both
   // words so either half can serve a later hit. A hit leaves the entry
   // untouched; a timeout or a flush of an in-flight request invalidates it
   // because the datapath may have been left in an unknown state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cache_valid_q <= 1'b0;
         cache_op_q    <= 3'd0;
         cache_rs1_q   <= 32'd0;
         cache_rs2_q   <= 32'd0;
         cache_high_q  <= 32'd0;
         cache_low_q   <= 32'd0;
      end else if (capture) begin
         cache_valid_q <= 1'b1;
         cache_op_q    <= op_q;
         cache_rs1_q   <= rs1_q;
         cache_rs2_q   <= rs2_q;
         cache_high_q  <= md_high_i;
         cache_low_q   <= md_low_i;
      end else if (timeout || abort) begin
         cache_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_div_ctrl
//
// Bench for mul_div_ctrl. A behavioural datapath answers md_req_o with the
// RISC-V M-extension results after 1 BUSY cycle (zero operand) or 32 BUSY
// cycles (otherwise), or never when hung. Expected write-back data comes
// from plain-arithmetic instruction semantics; expected latency from a
// small model of the result cache.
// ---------------------------------------------------------------------------
module tb_mul_div_ctrl;

   localparam int MAX_CYCLES = 40;
   localparam int LAT_HIT    = 1;
   localparam int LAT_ZERO   = 2;
   localparam int LAT_FULL   = 33;

   logic        clk_i;
   logic        rst_ni;
   logic        req_valid_i;
   logic [2:0]  req_op_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [4:0]  req_rd_i;
   logic        flush_i;
   logic        md_req_o;
   logic [2:0]  md_op_o;
   logic [6:0]  md_opcode_o;
   logic [31:0] md_rs1_o;
   logic [31:0] md_rs2_o;
   logic        md_ready_i;
   logic [31:0] md_high_i;
   logic [31:0] md_low_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        err_o;

   int   totalChecks = 0;
   int   badChecks   = 0;
   logic dpHang;
   int   dpCnt;
   logic stallAtReq;

   logic        mValid;
   logic [2:0]  mOp;
   logic [31:0] mA;
   logic [31:0] mB;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expData;
      int          expLat;
   } vec_t;

   vec_t vecs[21];

   mul_div_ctrl #(.MAX_CYCLES(MAX_CYCLES)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_op_i    (req_op_i),
      .req_rs1_i   (req_rs1_i),
      .req_rs2_i   (req_rs2_i),
      .req_rd_i    (req_rd_i),
      .flush_i     (flush_i),
      .md_req_o    (md_req_o),
      .md_op_o     (md_op_o),
      .md_opcode_o (md_opcode_o),
      .md_rs1_o    (md_rs1_o),
      .md_rs2_o    (md_rs2_o),
      .md_ready_i  (md_ready_i),
      .md_high_i   (md_high_i),
      .md_low_i    (md_low_i),
      .stall_o     (stall_o),
      .wb_valid_o  (wb_valid_o),
      .wb_rd_o     (wb_rd_o),
      .wb_data_o   (wb_data_o),
      .err_o       (err_o)
   );

   // Free-running 10 ns clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // RISC-V M-extension semantics, including divide-by-zero and the
   // signed-overflow special case.
   function automatic logic [31:0] refResult(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0]        pss, psu, puu;
      logic signed [31:0] sa, sb;
      logic [31:0]        r;
      logic               ovf;
      pss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      psu = {{32{a[31]}}, a} * {32'd0, b};
      puu = {32'd0, a} * {32'd0, b};
      sa  = a;
      sb  = b;
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (op)
         3'd0: r = pss[31:0];
         3'd1: r = pss[63:32];
         3'd2: r = psu[63:32];
         3'd3: r = puu[63:32];
         3'd4: r = (b == 0) ? 32'hFFFFFFFF : (ovf ? a : 32'(sa / sb));
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Both words a real datapath would produce for one run.
   function automatic logic [63:0] dpWords(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0, 3'd1: return {refResult(3'd1, a, b), refResult(3'd0, a, b)};
         3'd2:       return {refResult(3'd2, a, b), refResult(3'd0, a, b)};
         3'd3:       return {refResult(3'd3, a, b), refResult(3'd0, a, b)};
         3'd4, 3'd6: return {refResult(3'd6, a, b), refResult(3'd4, a, b)};
         default:    return {refResult(3'd7, a, b), refResult(3'd5, a, b)};
      endcase
   endfunction

   // Cache-hit rule for the reference model.
   function automatic logic modelHit(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return mValid && (a == mA) && (b == mB)
             && ((op == mOp) || (op[2] && mOp[2] && op[0] == mOp[0])
                 || (op == 3'd0 && !mOp[2]));
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'd7;
         default: return $urandom;
      endcase
   endfunction

   // Behavioural datapath: counts cycles of md_req_o and answers after one
   // cycle if an operand is zero, else after 32, unless hung.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dpCnt <= 0;
      end else if (md_req_o) begin
         dpCnt <= dpCnt + 1;
      end else begin
         dpCnt <= 0;
      end
   end

   assign md_ready_i = md_req_o && !dpHang
                       && (dpCnt == ((md_rs1_o == 32'd0 || md_rs2_o == 32'd0) ? 0 : 31));
   assign {md_high_i, md_low_i} = dpWords(md_op_o, md_rs1_o, md_rs2_o);

   // Global time limit so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL global timeout reached");
      $fatal(1, "[TB] timeout");
   end

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present one request for a single accepting edge, then drop it and
   // scramble the request lines. Returns #1 after the first negedge past
   // the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_rs1_i   = a;
      req_rs2_i   = b;
      req_rd_i    = rd;
      flush_i     = 1'b0;
      #1;
      stallAtReq = stall_o;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_op_i    = 3'($urandom);
      req_rs1_i   = $urandom;
      req_rs2_i   = $urandom;
      req_rd_i    = 5'($urandom);
      #1;
   endtask

   // Issue one instruction and check latency, data, rd, error flag, stall
   // behaviour, datapath request count and operand stability.
   task automatic runOp(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expData,
                        input int expLat, input logic expErr);
      logic predictedHit;
      int   lat;
      int   stallBad;
      int   reqSeen;
      int   holdBad;
      predictedHit = modelHit(op, a, b);
      lat      = 0;
      stallBad = 0;
      reqSeen  = 0;
      holdBad  = 0;
      applyStimulus(op, a, b, rd);
      checkOutput($sformatf("%s stall at request", name), 32'(stallAtReq), 32'd1);
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) begin
            @(negedge clk_i);
            #1;
         end
         if (wb_valid_o) begin
            lat = k;
            break;
         end
         if (!stall_o) stallBad++;
         if (md_req_o) begin
            reqSeen++;
            if (md_rs1_o != a || md_rs2_o != b || md_op_o != op) holdBad++;
         end
      end
      checkOutput($sformatf("%s latency", name), 32'(lat), 32'(expLat));
      checkOutput($sformatf("%s data", name), wb_data_o, expData);
      checkOutput($sformatf("%s rd", name), 32'(wb_rd_o), 32'(rd));
      checkOutput($sformatf("%s err", name), 32'(err_o), 32'(expErr));
      checkOutput($sformatf("%s stall in done", name), 32'(stall_o), 32'd0);
      checkOutput($sformatf("%s stall gaps", name), 32'(stallBad), 32'd0);
      checkOutput($sformatf("%s md_req cycles", name), 32'(reqSeen), 32'(expLat - 1));
      checkOutput($sformatf("%s operand hold", name), 32'(holdBad), 32'd0);
      if (expErr) begin
         mValid = 1'b0;
      end else if (!predictedHit) begin
         mValid = 1'b1;
         mOp    = op;
         mA     = a;
         mB     = b;
      end
   endtask

   // Checks that every reset-cleared output is zero right now.
   task automatic checkAllZero(input string tag);
      checkOutput($sformatf("%s md_req", tag), 32'(md_req_o), 32'd0);
      checkOutput($sformatf("%s stall", tag), 32'(stall_o), 32'd0);
      checkOutput($sformatf("%s wb_valid", tag), 32'(wb_valid_o), 32'd0);
      checkOutput($sformatf("%s err", tag), 32'(err_o), 32'd0);
      checkOutput($sformatf("%s wb_data", tag), wb_data_o, 32'd0);
      checkOutput($sformatf("%s wb_rd", tag), 32'(wb_rd_o), 32'd0);
      checkOutput($sformatf("%s md_rs1", tag), md_rs1_o, 32'd0);
      checkOutput($sformatf("%s md_rs2", tag), md_rs2_o, 32'd0);
      checkOutput($sformatf("%s md_op", tag), 32'(md_op_o), 32'd0);
   endtask

   // Random instructions; operands sometimes repeat to exercise the cache.
   task automatic runRandom(input int count);
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          expLat;
      a = 32'd1;
      b = 32'd1;
      for (int i = 0; i < count; i++) begin
         op = 3'($urandom_range(0, 7));
         if (i == 0 || $urandom_range(0, 2) != 0) begin
            a = pickOperand();
            b = pickOperand();
         end
         if (modelHit(op, a, b)) expLat = LAT_HIT;
         else if (a == 32'd0 || b == 32'd0) expLat = LAT_ZERO;
         else expLat = LAT_FULL;
         runOp($sformatf("rand%0d op%0d", i, op), op, a, b, 5'($urandom),
               refResult(op, a, b), expLat, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
   endtask

   // Main sequence.
   initial begin
      int seen;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL};
      vecs[1]  = '{3'd4, 32'd100,        32'd7,        32'd14,       LAT_FULL};
      vecs[2]  = '{3'd6, 32'd100,        32'd7,        32'd2,        LAT_HIT};
      vecs[3]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, LAT_ZERO};
      vecs[4]  = '{3'd7, 32'd5,          32'd0,        32'd5,        LAT_HIT};
      vecs[5]  = '{3'd1, 32'h80000001,   32'h80000001, 32'h3FFFFFFF, LAT_FULL};
      vecs[6]  = '{3'd0, 32'h80000001,   32'h80000001, 32'd1,        LAT_HIT};
      vecs[7]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, LAT_FULL};
      vecs[8]  = '{3'd3, 32'hFFFFFFFF,   32'd2,        32'd1,        LAT_FULL};
      vecs[9]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, LAT_FULL};
      vecs[10] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        LAT_HIT};
      vecs[11] = '{3'd5, 32'd0,          32'd9,        32'd0,        LAT_ZERO};
      vecs[12] = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, LAT_FULL};
      vecs[13] = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, LAT_HIT};
      vecs[14] = '{3'd1, 32'd5,          32'd7,        32'd0,        LAT_FULL};
      vecs[15] = '{3'd0, 32'd5,          32'd7,        32'd35,       LAT_HIT};
      vecs[16] = '{3'd3, 32'd5,          32'd7,        32'd0,        LAT_FULL};
      vecs[17] = '{3'd0, 32'd6,          32'd6,        32'd36,       LAT_FULL};
      vecs[18] = '{3'd1, 32'd6,          32'd6,        32'd0,        LAT_FULL};
      vecs[19] = '{3'd4, 32'd100,        32'd7,        32'd14,       LAT_FULL};
      vecs[20] = '{3'd5, 32'd100,        32'd7,        32'd14,       LAT_FULL};

      rst_ni      = 1'b1;
      req_valid_i = 1'b0;
      req_op_i    = 3'd0;
      req_rs1_i   = 32'd0;
      req_rs2_i   = 32'd0;
      req_rd_i    = 5'd0;
      flush_i     = 1'b0;
      dpHang      = 1'b0;
      mValid      = 1'b0;
      mOp         = 3'd0;
      mA          = 32'd0;
      mB          = 32'd0;

      #3 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      checkAllZero("reset");
      checkOutput("reset opcode", 32'(md_opcode_o), 32'h33);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      checkOutput("after release md_req", 32'(md_req_o), 32'd0);

      for (int i = 0; i < 21; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               5'(i + 1), vecs[i].expData, vecs[i].expLat, 1'b0);
      end

      // Flush in IDLE wins over a valid request.
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_op_i    = 3'd0;
      req_rs1_i   = 32'd2;
      req_rs2_i   = 32'd3;
      flush_i     = 1'b1;
      #1;
      checkOutput("idle flush stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      flush_i     = 1'b0;
      #1;
      checkOutput("idle flush md_req", 32'(md_req_o), 32'd0);
      checkOutput("idle flush wb_valid", 32'(wb_valid_o), 32'd0);

      // Flush in DONE gates the write-back (REMU hits the cached DIVU).
      applyStimulus(3'd7, 32'd100, 32'd7, 5'd12);
      flush_i = 1'b1;
      #1;
      checkOutput("done flush wb_valid", 32'(wb_valid_o), 32'd0);
      checkOutput("done flush err", 32'(err_o), 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      checkOutput("done flush back idle wb_valid", 32'(wb_valid_o), 32'd0);
      checkOutput("done flush back idle md_req", 32'(md_req_o), 32'd0);

      // Flush at BUSY cycle 10 drops the request and clears the cache.
      runOp("mulh m1*m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'd0, LAT_FULL, 1'b0);
      applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
      repeat (9) @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      checkOutput("busy flush md_req before", 32'(md_req_o), 32'd1);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      checkOutput("busy flush md_req after", 32'(md_req_o), 32'd0);
      checkOutput("busy flush stall after", 32'(stall_o), 32'd0);
      seen = 0;
      repeat (45) begin
         @(negedge clk_i);
         #1;
         if (wb_valid_o) seen++;
      end
      checkOutput("busy flush no writeback", 32'(seen), 32'd0);
      mValid = 1'b0;
      runOp("mulh reissue", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'd0, LAT_FULL, 1'b0);
      runOp("mulhu reissue", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, LAT_FULL, 1'b0);

      // Watchdog: hung datapath forces an error write-back of zero and
      // invalidates the cache.
      runOp("mul 3*5", 3'd0, 32'd3, 32'd5, 5'd9, 32'd15, LAT_FULL, 1'b0);
      dpHang = 1'b1;
      runOp("watchdog", 3'd1, 32'd3, 32'd5, 5'd10, 32'd0, MAX_CYCLES + 1, 1'b1);
      dpHang = 1'b0;
      runOp("mul after watchdog", 3'd0, 32'd3, 32'd5, 5'd11, 32'd15, LAT_FULL, 1'b0);

      // Reset in the middle of BUSY.
      applyStimulus(3'd0, 32'd9, 32'd9, 5'd3);
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkAllZero("mid-busy reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      mValid = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         #1;
         if (wb_valid_o || md_req_o) seen++;
      end
      checkOutput("after reset quiet", 32'(seen), 32'd0);
      runOp("mul 3*4 after reset", 3'd0, 32'd3, 32'd4, 5'd13, 32'd12, LAT_FULL, 1'b0);

      runRandom(40);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
